// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the BRAM line loader.
// Optional feature macro used by the loader: BRAM_LINE_PAD_EN (zero-pad and keep a trailing partial line).
package bram_loader_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_RDY,
      LOAD,
      ARMED
   } loader_state_t;

   // Lane counter width; a single-lane line still needs a one-bit counter.
   function automatic int lane_bits(input int nl);
      return (nl > 1) ? $clog2(nl) : 1;
   endfunction

endpackage

// File: rtl/bram_line_loader_line_packer.sv
// Packs 32-bit beats into lines, lane 0 first; the line buffer is zeroed after each emitted line
// so any lanes not filled before a tlast read as zero.
module line_packer
   import bram_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  beat_valid,
   input  logic [WORD_W-1:0]     beat_data,
   input  logic                  beat_last,
   output logic [DATA_WIDTH-1:0] line,
   output logic                  line_valid,
   output logic                  partial
);

   localparam int NL = DATA_WIDTH / WORD_W;
   localparam int LW = lane_bits(NL);

   logic [LW-1:0]         lane_q, lane_d;
   logic [DATA_WIDTH-1:0] line_buf_q, line_buf_d;
   logic [DATA_WIDTH-1:0] merged;
   logic                  lane_full;

   generate
      for (genvar gi = 0; gi < NL; gi++) begin : g_lane
         assign merged[gi*WORD_W +: WORD_W] = (beat_valid && (lane_q == LW'(gi))) ?
                                              beat_data : line_buf_q[gi*WORD_W +: WORD_W];
      end
   endgenerate

   assign lane_full = (lane_q == LW'(NL - 1));

   always_comb begin
      line       = merged;
      line_valid = beat_valid && (lane_full || beat_last);
      partial    = line_valid && !lane_full;
      lane_d     = lane_q;
      line_buf_d = line_buf_q;
      if (clr) begin
         lane_d     = '0;
         line_buf_d = '0;
      end else if (beat_valid) begin
         if (line_valid) begin
            lane_d     = '0;
            line_buf_d = '0;
         end else begin
            lane_d     = lane_q + LW'(1);
            line_buf_d = merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q     <= '0;
         line_buf_q <= '0;
      end else begin
         lane_q     <= lane_d;
         line_buf_q <= line_buf_d;
      end
   end

endmodule

// File: rtl/bram_line_loader.sv
// Streams 32-bit words into DATA_WIDTH-bit BRAM lines: clear, wait for write_rdy, load from address 0, arm.
// Optional macro BRAM_LINE_PAD_EN: a trailing partial line is zero-padded and written instead of dropped.
module bram_line_loader
   import bram_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int BRAM_DEPTH = 2048,
   localparam int AW = $clog2(BRAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [WORD_W-1:0]     s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   input  logic                  write_rdy,
   output logic [AW-1:0]         addr,
   output logic [DATA_WIDTH-1:0] line_in,
   output logic                  we,
   output logic                  en,
   output logic                  clr_bram,
   output logic                  generator_mode,
   output logic [AW:0]           lines_written,
   output logic                  load_done,
   output logic                  overflow
);

`ifdef BRAM_LINE_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   loader_state_t         state_q, state_d;
   logic                  we_q, we_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] line_q, line_d;
   logic [AW:0]           lines_written_q, lines_written_d;
   logic                  overflow_q, overflow_d;
   logic                  load_done_q, load_done_d;
   logic                  arm_pend_q, arm_pend_d;

   logic                  accept, at_depth, commit;
   logic [DATA_WIDTH-1:0] pk_line;
   logic                  pk_valid, pk_partial;

   // No beat is taken on a write cycle or while waiting to arm after tlast.
   assign s_tready = (state_q == LOAD) && !we_q && !arm_pend_q;
   assign accept   = s_tvalid && s_tready;
   assign at_depth = (lines_written_q == (AW+1)'(BRAM_DEPTH));
   assign commit   = pk_valid && (PAD_EN || !pk_partial);

   line_packer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (state_q == CLEAR),
      .beat_valid (accept && !at_depth),
      .beat_data  (s_tdata),
      .beat_last  (s_tlast),
      .line       (pk_line),
      .line_valid (pk_valid),
      .partial    (pk_partial)
   );

   always_comb begin
      state_d         = state_q;
      we_d            = 1'b0;
      addr_d          = addr_q;
      line_d          = line_q;
      lines_written_d = lines_written_q;
      overflow_d      = overflow_q;
      load_done_d     = 1'b0;
      arm_pend_d      = arm_pend_q;
      case (state_q)
         IDLE, ARMED: begin
            if (load_start) begin
               state_d         = CLEAR;
               lines_written_d = '0;
               overflow_d      = 1'b0;
               arm_pend_d      = 1'b0;
            end
         end
         CLEAR: state_d = WAIT_RDY;
         WAIT_RDY: begin
            if (write_rdy) state_d = LOAD;
         end
         LOAD: begin
            if (arm_pend_q) begin
               state_d     = ARMED;
               load_done_d = 1'b1;
               arm_pend_d  = 1'b0;
            end else if (accept) begin
               // Past the last line the beat is swallowed; addr never wraps.
               if (at_depth) overflow_d = 1'b1;
               if (commit) begin
                  we_d            = 1'b1;
                  addr_d          = lines_written_q[AW-1:0];
                  line_d          = pk_line;
                  lines_written_d = lines_written_q + (AW+1)'(1);
               end
               if (s_tlast) arm_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         we_q            <= 1'b0;
         addr_q          <= '0;
         line_q          <= '0;
         lines_written_q <= '0;
         overflow_q      <= 1'b0;
         load_done_q     <= 1'b0;
         arm_pend_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         we_q            <= we_d;
         addr_q          <= addr_d;
         line_q          <= line_d;
         lines_written_q <= lines_written_d;
         overflow_q      <= overflow_d;
         load_done_q     <= load_done_d;
         arm_pend_q      <= arm_pend_d;
      end
   end

   assign we             = we_q;
   assign en             = we_q;
   assign addr           = addr_q;
   assign line_in        = line_q;
   assign clr_bram       = (state_q == CLEAR);
   assign generator_mode = (state_q == ARMED);
   assign lines_written  = lines_written_q;
   assign load_done      = load_done_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_bram_line_loader.sv
// Randomised bench for bram_line_loader (64-bit lines, 4-line BRAM) with a beat-indexed reference model.
module tb_bram_line_loader;

   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int NL    = DW / 32;
   localparam int AW    = $clog2(DEPTH);
`ifdef BRAM_LINE_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, load_start, s_tvalid, s_tlast, write_rdy;
   logic [31:0]   s_tdata;
   logic          s_tready, we, en, clr_bram, generator_mode, load_done, overflow;
   logic [AW-1:0] addr;
   logic [DW-1:0] line_in;
   logic [AW:0]   lines_written;

   always #5 clk = ~clk;

   bram_line_loader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .s_tdata(s_tdata),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .write_rdy(write_rdy),
      .addr(addr), .line_in(line_in), .we(we), .en(en), .clr_bram(clr_bram),
      .generator_mode(generator_mode), .lines_written(lines_written),
      .load_done(load_done), .overflow(overflow)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference model: beat i belongs to line i/NL, lane i%NL; lines at or past DEPTH are discarded.
   int            model_lw, beat_idx, arm_cd, clr_cnt, ld_cnt;
   bit            model_ovf, model_armed, pend, arm_evt;
   logic [DW-1:0] cur_line;
   int            exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   int            wr_addr_log[$];
   logic [DW-1:0] wr_data_log[$];

   task automatic model_reset();
      model_lw = 0; beat_idx = 0; arm_cd = 0; model_ovf = 0; model_armed = 0;
      pend = 0; cur_line = '0;
      exp_addr_q.delete(); exp_data_q.delete();
   endtask

   initial model_reset();

   always @(negedge clk) begin
      int li, ln;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (clr_bram) begin
            clr_cnt++;
            model_reset();
         end
         chk("we", we, pend);
         chk("en", en, we);
         if (we) begin
            wr_addr_log.push_back(int'(addr));
            wr_data_log.push_back(line_in);
            if (exp_addr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write: got addr %0h want no write", addr);
            end else begin
               chk("addr", addr, exp_addr_q.pop_front());
               chk("line_in", line_in, exp_data_q.pop_front());
            end
         end
         if (pend) model_lw++;
         pend = 0;
         chk("lines_written", lines_written, model_lw);
         chk("overflow", overflow, model_ovf);
         arm_evt = 0;
         if (arm_cd > 0) begin
            arm_cd--;
            if (arm_cd == 0) begin
               model_armed = 1;
               arm_evt = 1;
            end
         end
         chk("load_done", load_done, arm_evt);
         chk("generator_mode", generator_mode, model_armed);
         if (model_armed || we) chk("tready_blocked", s_tready, 0);
         if (load_done) ld_cnt++;
         if (s_tvalid && s_tready) begin
            li = beat_idx / NL;
            ln = beat_idx % NL;
            if (li >= DEPTH) begin
               model_ovf = 1;
            end else begin
               cur_line[ln*32 +: 32] = s_tdata;
               if (ln == NL - 1 || (s_tlast && PAD)) begin
                  exp_addr_q.push_back(li);
                  exp_data_q.push_back(cur_line);
                  pend = 1;
               end
               if (ln == NL - 1 || s_tlast) cur_line = '0;
            end
            beat_idx++;
            if (s_tlast) arm_cd = 2;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_addr_log.delete(); wr_data_log.delete();
      clr_cnt = 0; ld_cnt = 0;
   endtask

   task automatic start_load(input int rdy_delay);
      write_rdy = (rdy_delay == 0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      @(negedge clk);
      chk("clr_pulse", clr_bram, 1);
      chk("mode_drop", generator_mode, 0);
      @(negedge clk);
      chk("clr_once", clr_bram, 0);
      for (int i = 0; i < rdy_delay; i++) begin
         @(negedge clk);
         chk("wait_tready", s_tready, 0);
         chk("wait_we", we, 0);
      end
      tick();
      write_rdy = 1'b1;
   endtask

   task automatic send_beat(input logic [31:0] d, input bit last, input int gap);
      int  n;
      bit  done;
      repeat (gap) tick();
      s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
      n = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (s_tready) done = 1;
         else if (++n > 40) begin
            total++; bad++;
            $display("FAIL beat_timeout: got no tready want tready within 40 cycles");
            done = 1;
         end
      end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic wait_armed();
      int n = 0;
      @(negedge clk);
      while (!generator_mode && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (!generator_mode) begin
         total++; bad++;
         $display("FAIL arm_timeout: got generator_mode 0 want 1");
      end
      repeat (2) tick();
   endtask

   task automatic run_load(input int nbeats, input int rdy_delay, input int maxgap, input int base);
      start_load(rdy_delay);
      for (int i = 0; i < nbeats; i++)
         send_beat((base < 0) ? $urandom : (base + i), i == nbeats - 1, $urandom_range(0, maxgap));
      wait_armed();
   endtask

   initial begin
      rst_n = 1'b0; load_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      s_tdata = '0; write_rdy = 1'b1;
      clear_logs();
      repeat (3) tick();
      @(negedge clk);
      chk("rst_mode", generator_mode, 0); chk("rst_we", we, 0);
      chk("rst_clr", clr_bram, 0); chk("rst_tready", s_tready, 0);
      chk("rst_lw", lines_written, 0); chk("rst_done", load_done, 0);
      chk("rst_ovf", overflow, 0); chk("rst_addr", addr, 0); chk("rst_line", line_in, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Four beats 1..4: two full lines.
      clear_logs();
      run_load(4, 0, 0, 1);
      chk("t1_clr_cnt", clr_cnt, 1);
      chk("t1_writes", wr_addr_log.size(), 2);
      chk("t1_addr0", wr_addr_log[0], 0);
      chk("t1_data0", wr_data_log[0], 64'h00000002_00000001);
      chk("t1_addr1", wr_addr_log[1], 1);
      chk("t1_data1", wr_data_log[1], 64'h00000004_00000003);
      chk("t1_lw", lines_written, 2);
      chk("t1_mode", generator_mode, 1);
      chk("t1_done_cnt", ld_cnt, 1);

      // Re-arm from ARMED with write_rdy held low for 10 cycles.
      clear_logs();
      run_load(2, 10, 0, 5);
      chk("t2_addr0", wr_addr_log[0], 0);
      chk("t2_data0", wr_data_log[0], 64'h00000006_00000005);
      chk("t2_lw", lines_written, 1);

      // Trailing partial line.
      clear_logs();
      run_load(3, 0, 0, 'hA);
      chk("t3_data0", wr_data_log[0], 64'h0000000B_0000000A);
      chk("t3_lw", lines_written, PAD ? 2 : 1);
`ifdef BRAM_LINE_PAD_EN
      chk("t3_data1", wr_data_log[1], 64'h00000000_0000000C);
`endif

      // Twelve beats into a four-line BRAM.
      clear_logs();
      run_load(12, 0, 1, 1);
      chk("t4_writes", wr_addr_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("t4_addr", wr_addr_log[i], i);
      chk("t4_data3", wr_data_log[3], 64'h00000008_00000007);
      chk("t4_ovf", overflow, 1);
      chk("t4_lw", lines_written, 4);
      chk("t4_mode", generator_mode, 1);

      // Random loads.
      for (int k = 0; k < 8; k++) begin
         clear_logs();
         run_load($urandom_range(1, 12), $urandom_range(0, 3), 3, -1);
         chk("rand_done_cnt", ld_cnt, 1);
      end

      // Reset in the middle of a load, then a fresh load.
      start_load(0);
      for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, $urandom_range(0, 2));
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_we", we, 0); chk("mid_rst_tready", s_tready, 0);
      chk("mid_rst_lw", lines_written, 0); chk("mid_rst_line", line_in, 0);
      chk("mid_rst_addr", addr, 0); chk("mid_rst_mode", generator_mode, 0);
      tick();
      rst_n = 1'b1;
      tick();
      clear_logs();
      run_load(4, 1, 2, -1);
      chk("post_rst_addr0", wr_addr_log[0], 0);
      chk("post_rst_lw", lines_written, 2);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
